// File: rtl/mem_arbiter_n_if.sv
// Bundle of requester-side and external-memory-side signals for mem_arbiter_n.
// The arbiter takes the slave modport; requesters and the RAM/IO model take master.
interface mem_arbiter_n_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0]      req_en;
    logic [N_CH-1:0]      req_rw;
    logic [N_CH*32-1:0]   req_addr;
    logic [N_CH*3-1:0]    req_len;
    logic [N_CH*32-1:0]   req_wdata;
    logic [N_CH-1:0]      done;
    logic [31:0]          rdata;
    logic [7:0]           mem_din;
    logic [7:0]           mem_dout;
    logic [31:0]          mem_a;
    logic                 mem_wr;
    logic                 io_buffer_full;

    modport slave (
        input  req_en, req_rw, req_addr, req_len, req_wdata, mem_din, io_buffer_full,
        output done, rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output req_en, req_rw, req_addr, req_len, req_wdata, mem_din, io_buffer_full,
        input  done, rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter_n.sv
// N-channel byte-serial arbiter/controller for the 8-bit external RAM/IO bus.
// Define MEMC_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mem_arbiter_n #(
    parameter int              N_CH          = 2,
    parameter logic [N_CH-1:0] ROLLBACK_MASK = {N_CH{1'b1}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            rollback,
    mem_arbiter_n_if.slave  bus
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, WAIT} state_t;

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic [IDX_W-1:0]  ch, ch_n;
    logic              rw, rw_n;
    logic [2:0]        len, len_n;
    logic [31:0]       addr, addr_n;
    logic [31:0]       wdata, wdata_n;
    logic [N_CH-1:0]   done_q, done_n;
    logic [31:0]       rdata_q, rdata_n;
    logic [31:0]       mem_a_q, mem_a_n;
    logic [7:0]        dout_q, dout_n;
    logic              wr_q, wr_n;
    logic [1:0]        bidx;

    logic [N_CH-1:0]   elig;
    logic              gnt_vld;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_rw;
    logic [31:0]       gnt_addr;
    logic [31:0]       gnt_wdata;
    logic [2:0]        gnt_len;
`ifndef MEMC_FIXED_PRIO_EN
    logic [IDX_W-1:0]  rr, rr_n;
`endif

    function automatic logic [2:0] clamp_len(input logic [2:0] l);
        if (l == 3'd0)      return 3'd1;
        else if (l > 3'd4)  return 3'd4;
        else                return l;
    endfunction

    function automatic logic is_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    // Read bytes land two edges after their address edge, so the capture lags cnt by 2.
    assign bidx = 2'(cnt - 3'd2);

    always_comb begin : grant_sel
        int sel;
        sel      = 0;
        gnt_vld  = 1'b0;
        // On rollback, pending reads of masked channels may not start.
        elig     = bus.req_en & ~(rollback ? (~bus.req_rw & ROLLBACK_MASK) : '0);
`ifdef MEMC_FIXED_PRIO_EN
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (elig[k]) begin
                gnt_vld = 1'b1;
                sel     = k;
            end
        end
`else
        // Scan farthest-first so the channel right after rr wins the last assignment.
        for (int j = N_CH; j >= 1; j--) begin
            if (elig[(int'(rr) + j) % N_CH]) begin
                gnt_vld = 1'b1;
                sel     = (int'(rr) + j) % N_CH;
            end
        end
`endif
        gnt_idx   = IDX_W'(sel);
        gnt_rw    = bus.req_rw[sel];
        gnt_addr  = bus.req_addr[32*sel +: 32];
        gnt_wdata = bus.req_wdata[32*sel +: 32];
        gnt_len   = bus.req_len[3*sel +: 3];
    end

    always_comb begin : next_state
        state_n = state;
        cnt_n   = cnt;
        ch_n    = ch;
        rw_n    = rw;
        len_n   = len;
        addr_n  = addr;
        wdata_n = wdata;
        done_n  = done_q;
        rdata_n = rdata_q;
        mem_a_n = '0;
        dout_n  = '0;
        wr_n    = 1'b0;
`ifndef MEMC_FIXED_PRIO_EN
        rr_n    = rr;
`endif
        case (state)
            IDLE: begin
                done_n = '0;
                if (gnt_vld) begin
                    state_n = BUSY;
                    ch_n    = gnt_idx;
                    rw_n    = gnt_rw;
                    len_n   = clamp_len(gnt_len);
                    addr_n  = gnt_addr;
                    wdata_n = gnt_wdata;
                    rdata_n = '0;
`ifndef MEMC_FIXED_PRIO_EN
                    rr_n    = gnt_idx;
`endif
                    if (gnt_rw && is_io(gnt_addr) && bus.io_buffer_full) begin
                        cnt_n = 3'd0;
                    end else begin
                        mem_a_n = gnt_addr;
                        dout_n  = gnt_rw ? gnt_wdata[7:0] : 8'h00;
                        wr_n    = gnt_rw;
                        cnt_n   = 3'd1;
                    end
                end
            end
            BUSY: begin
                if (rw) begin
                    if (cnt == len) begin
                        state_n      = WAIT;
                        done_n       = '0;
                        done_n[ch]   = 1'b1;
                    end else if (!(is_io(addr) && bus.io_buffer_full)) begin
                        mem_a_n = addr + {29'd0, cnt};
                        dout_n  = byte_sel(wdata, cnt[1:0]);
                        wr_n    = 1'b1;
                        cnt_n   = cnt + 3'd1;
                    end
                end else if (rollback && ROLLBACK_MASK[ch]) begin
                    state_n = IDLE;
                    cnt_n   = 3'd0;
                end else begin
                    if (cnt >= 3'd2)
                        rdata_n = rdata_q | (32'(bus.mem_din) << {bidx, 3'b000});
                    if (cnt == len + 3'd1) begin
                        state_n    = WAIT;
                        done_n     = '0;
                        done_n[ch] = 1'b1;
                    end else begin
                        if (cnt < len)
                            mem_a_n = addr + {29'd0, cnt};
                        cnt_n = cnt + 3'd1;
                    end
                end
            end
            WAIT: begin
                state_n = IDLE;
                done_n  = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            ch      <= '0;
            rw      <= 1'b0;
            len     <= 3'd1;
            done_q  <= '0;
            rdata_q <= '0;
            mem_a_q <= '0;
            dout_q  <= '0;
            wr_q    <= 1'b0;
`ifndef MEMC_FIXED_PRIO_EN
            rr      <= '0;
`endif
        end else if (!rdy) begin
            // Frozen: only the write strobe drops so a held byte is not written twice.
            wr_q    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ch      <= ch_n;
            rw      <= rw_n;
            len     <= len_n;
            done_q  <= done_n;
            rdata_q <= rdata_n;
            mem_a_q <= mem_a_n;
            dout_q  <= dout_n;
            wr_q    <= wr_n;
`ifndef MEMC_FIXED_PRIO_EN
            rr      <= rr_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            addr  <= addr_n;
            wdata <= wdata_n;
        end
    end

    assign bus.done     = done_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = dout_q;
    assign bus.mem_wr   = wr_q;
endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter_n;
    localparam int         N    = 2;
    localparam logic [1:0] MASK = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic rollback = 1'b0;

    mem_arbiter_n_if #(.N_CH(N)) bus ();

    mem_arbiter_n #(.N_CH(N), .ROLLBACK_MASK(MASK)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM/IO model: preloaded bytes, otherwise a hash of the address; 1-cycle latency.
    logic [7:0] pre [logic [31:0]];

    function automatic logic [7:0] rom(input logic [31:0] a);
        if (pre.exists(a)) return pre[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    always @(posedge clk) bus.mem_din <= rom(bus.mem_a);

    function automatic int clamp(input logic [2:0] l);
        if (l == 3'd0) return 1;
        if (l > 3'd4)  return 4;
        return int'(l);
    endfunction

    // Reference model: one transaction at a time, described by bytes sent / edges elapsed.
    logic [31:0]  e_a, e_rdata;
    logic [7:0]   e_dout;
    logic         e_wr;
    logic [N-1:0] e_done;
    bit           m_act, m_cool, m_fresh, m_rw;
    int           m_rr, m_ch, m_len, m_step, m_sent;
    logic [31:0]  m_addr, m_wdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 0; m_cool = 0; m_rr = 0;
            e_a = '0; e_dout = '0; e_wr = 1'b0; e_done = '0; e_rdata = '0;
        end else if (!rdy) begin
            e_wr = 1'b0;
        end else if (m_cool) begin
            m_cool = 0;
            e_done = '0;
        end else begin
            m_fresh = 0;
            if (!m_act) begin
                logic [N-1:0] el;
                int w;
                w = -1;
                e_a = '0; e_wr = 1'b0; e_dout = '0; e_done = '0;
                el = bus.req_en & ~(rollback ? (~bus.req_rw & MASK) : '0);
`ifdef MEMC_FIXED_PRIO_EN
                for (int c = 0; c < N; c++) if (w < 0 && el[c]) w = c;
`else
                for (int k = 1; k <= N; k++) if (w < 0 && el[(m_rr + k) % N]) w = (m_rr + k) % N;
`endif
                if (w >= 0) begin
                    m_act = 1; m_fresh = 1; m_ch = w; m_rr = w;
                    m_rw = bus.req_rw[w];
                    m_addr = bus.req_addr[32*w +: 32];
                    m_wdata = bus.req_wdata[32*w +: 32];
                    m_len = clamp(bus.req_len[3*w +: 3]);
                    m_step = 0; m_sent = 0;
                    e_rdata = '0;
                end
            end
            if (m_act) begin
                if (m_rw) begin
                    if (m_sent == m_len) begin
                        e_done = '0; e_done[m_ch] = 1'b1;
                        e_rdata = '0; e_a = '0; e_wr = 1'b0; e_dout = '0;
                        m_act = 0; m_cool = 1;
                    end else if (m_addr[17:16] == 2'b11 && bus.io_buffer_full) begin
                        e_a = '0; e_wr = 1'b0; e_dout = '0;
                    end else begin
                        e_a = m_addr + 32'(m_sent);
                        e_dout = 8'(m_wdata >> (8 * m_sent));
                        e_wr = 1'b1;
                        m_sent++;
                    end
                end else if (!m_fresh && rollback && MASK[m_ch]) begin
                    m_act = 0; e_a = '0;
                end else begin
                    e_a = (m_step < m_len) ? m_addr + 32'(m_step) : 32'h0;
                    if (m_step == m_len + 1) begin
                        e_rdata = '0;
                        for (int k = 0; k < m_len; k++)
                            e_rdata = e_rdata | (32'(rom(m_addr + 32'(k))) << (8 * k));
                        e_done = '0; e_done[m_ch] = 1'b1;
                        m_act = 0; m_cool = 1;
                    end
                    m_step++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("mem_a", bus.mem_a, e_a);
        check("mem_wr", 32'(bus.mem_wr), 32'(e_wr));
        check("mem_dout", 32'(bus.mem_dout), 32'(e_dout));
        check("done", 32'(bus.done), 32'(e_done));
        if (e_done != '0 || rst) check("rdata", bus.rdata, e_rdata);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int c, input logic w, input logic [31:0] a,
                           input logic [2:0] l, input logic [31:0] d);
        bus.req_en[c] = 1'b1;
        bus.req_rw[c] = w;
        bus.req_addr[32*c +: 32] = a;
        bus.req_len[3*c +: 3] = l;
        bus.req_wdata[32*c +: 32] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    logic [31:0] t2_a [6] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h0, 32'h0};
    logic [1:0]  t2_d [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    logic [7:0]  t6_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    bit          pend [N];

    initial begin
        int got [$];
        int waited;
        bus.req_en = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_len = '0;
        bus.req_wdata = '0; bus.io_buffer_full = 1'b0;
        pre[32'h100] = 8'h11; pre[32'h101] = 8'h22; pre[32'h102] = 8'h33; pre[32'h103] = 8'h44;
        do_reset();
        check("reset_mem_a", bus.mem_a, 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);

        // Reset pulse during a read.
        set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
        step();
        step();
        check("t1_pre_mem_a", bus.mem_a, 32'h101);
        #1 rst = 1'b1;
        #1;
        check("t1_async_mem_a", bus.mem_a, 32'h0);
        check("t1_async_done", 32'(bus.done), 32'h0);
        check("t1_async_rdata", bus.rdata, 32'h0);
        check("t1_async_wr", 32'(bus.mem_wr), 32'h0);
        bus.req_en = '0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check("t1_no_done", 32'(bus.done), 32'h0);
        end

        // Four-byte read from preloaded RAM.
        set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
        for (int k = 0; k < 6; k++) begin
            step();
            check("t2_mem_a", bus.mem_a, t2_a[k]);
            check("t2_done", 32'(bus.done), 32'(t2_d[k]));
        end
        check("t2_rdata", bus.rdata, 32'h44332211);
        check("t2_model_rdata", e_rdata, 32'h44332211);
        bus.req_en = '0;
        step();

        // Arbitration order with both channels requesting continuously.
        do_reset();
        set_req(0, 1'b0, 32'h10, 3'd1, 32'h0);
        set_req(1, 1'b0, 32'h20, 3'd1, 32'h0);
        waited = 0;
        while (got.size() < 4 && waited < 60) begin
            step();
            waited++;
            if (bus.done != '0) got.push_back(bus.done[1] ? 1 : 0);
        end
        bus.req_en = '0;
        check("t3_count", 32'(got.size()), 32'd4);
        for (int k = 0; k < got.size(); k++) begin
`ifdef MEMC_FIXED_PRIO_EN
            check("t3_order", 32'(got[k]), 32'd0);
`else
            check("t3_order", 32'(got[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
`endif
        end
        for (int k = 0; k < 4; k++) step();

        // IO write stalled by a full UART buffer.
        bus.io_buffer_full = 1'b1;
        set_req(1, 1'b1, 32'h30000, 3'd1, 32'h41);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_stall_wr", 32'(bus.mem_wr), 32'h0);
        end
        bus.io_buffer_full = 1'b0;
        step();
        check("t4_wr", 32'(bus.mem_wr), 32'h1);
        check("t4_mem_a", bus.mem_a, 32'h30000);
        check("t4_dout", 32'(bus.mem_dout), 32'h41);
        step();
        check("t4_done", 32'(bus.done), 32'h2);
        check("t4_wr_after", 32'(bus.mem_wr), 32'h0);
        bus.req_en = '0;
        step();

        // Rollback kills a masked read; the arbiter is free on the next edge.
        set_req(0, 1'b0, 32'h500, 3'd4, 32'h0);
        step();
        step();
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        bus.req_en = '0;
        check("t5_kill_mem_a", bus.mem_a, 32'h0);
        set_req(1, 1'b0, 32'h600, 3'd1, 32'h0);
        step();
        check("t5_regrant", bus.mem_a, 32'h600);
        waited = 0;
        while (bus.done == '0 && waited < 10) begin
            step();
            waited++;
        end
        check("t5_regrant_done", 32'(bus.done), 32'h2);
        bus.req_en = '0;
        step();

        // Rollback does not affect a write.
        set_req(0, 1'b1, 32'h700, 3'd4, 32'hDDCCBBAA);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) rollback = 1'b1;
            step();
            rollback = 1'b0;
            check("t5w_mem_a", bus.mem_a, 32'h700 + 32'(k));
            check("t5w_dout", 32'(bus.mem_dout), 32'hAA + 32'(k) * 32'h11);
        end
        step();
        check("t5w_done", 32'(bus.done), 32'h1);
        bus.req_en = '0;
        step();

        // Two-cycle freeze in the middle of a write.
        set_req(0, 1'b1, 32'h400, 3'd4, 32'h44332211);
        for (int k = 0; k < 2; k++) begin
            step();
            check("t6_mem_a", bus.mem_a, 32'h400 + 32'(k));
            check("t6_dout", 32'(bus.mem_dout), 32'(t6_b[k]));
        end
        rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("t6_freeze_wr", 32'(bus.mem_wr), 32'h0);
            check("t6_freeze_done", 32'(bus.done), 32'h0);
        end
        rdy = 1'b1;
        for (int k = 2; k < 4; k++) begin
            step();
            check("t6_mem_a", bus.mem_a, 32'h400 + 32'(k));
            check("t6_dout", 32'(bus.mem_dout), 32'(t6_b[k]));
            check("t6_wr", 32'(bus.mem_wr), 32'h1);
        end
        step();
        check("t6_done", 32'(bus.done), 32'h1);
        bus.req_en = '0;
        step();

        // Randomized traffic; requesters hold until their done, then drop.
        for (int c = 0; c < N; c++) pend[c] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (pend[c] && e_done[c]) begin
                    bus.req_en[c] = 1'b0;
                    pend[c] = 0;
                end else if (!pend[c] && $urandom_range(2) == 0) begin
                    logic [31:0] a;
                    case ($urandom_range(3))
                        0:       a = 32'hFFFF_FFFC + 32'($urandom_range(3));
                        1:       a = {$urandom_range(16'hFFFF, 0) > 0 ? 14'h1234 : 14'h0, 2'b11, 16'($urandom)};
                        default: a = $urandom;
                    endcase
                    set_req(c, 1'($urandom_range(1)), a, 3'($urandom_range(7)), $urandom);
                    pend[c] = 1;
                end
            end
            bus.io_buffer_full = ($urandom_range(2) == 0);
            rollback = ($urandom_range(15) == 0);
            step();
        end
        bus.req_en = '0;
        rollback = 1'b0;
        bus.io_buffer_full = 1'b0;
        for (int k = 0; k < 10; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
